// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture engine.
package la_pkg;

    // Capture/readout controller states.
    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StArmed,
        StPost,
        StDone,
        StRead
    } la_state_e;

    // Trigger mode encodings as seen on trig_mode_i.
    localparam logic [1:0] TM_LEVEL  = 2'd0;
    localparam logic [1:0] TM_RISE   = 2'd1;
    localparam logic [1:0] TM_FALL   = 2'd2;
    localparam logic [1:0] TM_CHANGE = 2'd3;

endpackage

// File: rtl/la_sdp_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module la_sdp_ram #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular pre/post-trigger capture and
// in-order valid/ready readout of the whole buffer, oldest sample first.
module la_capture_core
    import la_pkg::*;
#(
    parameter int unsigned DATA_W    = 96,
    parameter int unsigned TRIG_W    = 8,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned PRE_DEPTH = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              sample_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_val_i,
    input  logic [1:0]        trig_mode_i,
    output logic              busy_o,
    output logic              trig_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    input  logic              rd_ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] PRE_N    = CW'(PRE_DEPTH);
    localparam logic [CW-1:0] POST_N   = CW'(DEPTH - PRE_DEPTH);
    localparam logic [CW-1:0] DEPTH_N  = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    la_state_e         r_state, w_state_nxt;
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_cnt, r_issue_cnt;
    logic [TRIG_W-1:0] r_prev_m;
    logic              r_prev_vld, r_trig;
    // Read-ahead pipeline: pending RAM read, skid slot, output slot.
    logic              r_pend, r_pend_last;
    logic              r_skid_vld, r_skid_last;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_out_vld, r_out_last;
    logic [DATA_W-1:0] r_out_data;

    logic [TRIG_W-1:0] w_m;
    logic              w_match, w_arm, w_we, w_fill_last, w_post_last, w_trig_hit;
    logic              w_pop, w_issue;
    logic [1:0]        w_occ;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_m         = trig_i & trig_mask_i;
    assign w_arm       = arm_i && (r_state == StIdle || r_state == StDone);
    assign w_we        = !abort_i && sample_en_i &&
                         (r_state == StFill || r_state == StArmed || r_state == StPost);
    assign w_fill_last = (r_cnt + CW'(1)) == PRE_N;
    assign w_post_last = (r_cnt + CW'(1)) == POST_N;
    assign w_trig_hit  = (r_state == StArmed) && sample_en_i && w_match;
    assign w_pop       = r_out_vld && rd_ready_i;
    assign w_occ       = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_pend};
    // Issue a read whenever the pending read will still find a free slot.
    assign w_issue     = (r_state == StRead) && !abort_i && (r_issue_cnt != DEPTH_N) &&
                         ((w_occ - {1'b0, w_pop}) < 2'd2);

    // Masked trigger comparator; edge modes need a valid previous sample.
    always_comb begin
        w_match = 1'b0;
        unique case (trig_mode_i)
            TM_LEVEL:  w_match = (w_m == (trig_val_i & trig_mask_i));
            TM_RISE:   w_match = r_prev_vld && |(w_m & ~r_prev_m);
            TM_FALL:   w_match = r_prev_vld && |(~w_m & r_prev_m);
            TM_CHANGE: w_match = r_prev_vld && (w_m != r_prev_m);
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; abort overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = StIdle;
        end else begin
            case (r_state)
                StIdle:  if (arm_i) w_state_nxt = (PRE_DEPTH == 0) ? StArmed : StFill;
                StFill:  if (sample_en_i && w_fill_last) w_state_nxt = StArmed;
                StArmed: if (w_trig_hit) w_state_nxt = (POST_N == CW'(1)) ? StDone : StPost;
                StPost:  if (sample_en_i && w_post_last) w_state_nxt = StDone;
                StDone:  begin
                    if (arm_i) w_state_nxt = (PRE_DEPTH == 0) ? StArmed : StFill;
                    else       w_state_nxt = StRead;
                end
                StRead:  if (w_pop && r_out_last) w_state_nxt = StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy_o     = (r_state == StFill) || (r_state == StArmed) || (r_state == StPost);
        done_o     = (r_state == StDone) || (r_state == StRead);
        trig_o     = r_trig;
        rd_valid_o = r_out_vld;
        rd_data_o  = r_out_data;
        rd_last_o  = r_out_vld && r_out_last;
    end

    // Capture datapath: write pointer, pre/post counter, edge history, sticky trigger.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_prev_m   <= '0;
            r_prev_vld <= 1'b0;
            r_trig     <= 1'b0;
        end else if (abort_i) begin
            r_trig     <= 1'b0;
            r_prev_vld <= 1'b0;
        end else if (w_arm) begin
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_prev_vld <= 1'b0;
            r_trig     <= 1'b0;
        end else if (w_we) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_prev_m   <= w_m;
            r_prev_vld <= 1'b1;
            case (r_state)
                StFill:  r_cnt <= w_fill_last ? '0 : r_cnt + CW'(1);
                StArmed: begin
                    if (w_match) begin
                        r_trig <= 1'b1;
                        r_cnt  <= CW'(1);
                    end
                end
                StPost:  r_cnt <= r_cnt + CW'(1);
                default: ;
            endcase
        end
    end

    // Readout datapath: prefetch from RAM through a skid slot into the output slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr    <= '0;
            r_issue_cnt <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
            r_skid_data <= '0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (abort_i || r_state != StRead) begin
            // Outside READ the write pointer marks the oldest sample.
            r_rd_ptr    <= r_wr_ptr;
            r_issue_cnt <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_pend      <= w_issue;
            r_pend_last <= w_issue && (r_issue_cnt == LAST_IDX);
            if (w_issue) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_issue_cnt <= r_issue_cnt + CW'(1);
            end
            if (!r_out_vld || rd_ready_i) begin
                if (r_skid_vld) begin
                    r_out_vld   <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_last  <= r_skid_last;
                    r_skid_vld  <= r_pend;
                    r_skid_data <= w_ram_rdata;
                    r_skid_last <= r_pend_last;
                end else begin
                    r_out_vld  <= r_pend;
                    r_out_last <= r_pend_last;
                    if (r_pend) begin
                        r_out_data <= w_ram_rdata;
                    end
                end
            end else if (r_pend) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= w_ram_rdata;
                r_skid_last <= r_pend_last;
            end
        end
    end

    la_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .waddr_i (r_wr_ptr),
        .wdata_i (data_i),
        .re_i    (w_issue),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_ram_rdata)
    );

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core with DEPTH=16, PRE_DEPTH=4, DATA_W=16.
module tb_la_capture_core;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        arm_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        sample_en_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [7:0]  trig_i = '0;
    logic [7:0]  trig_mask_i = '0;
    logic [7:0]  trig_val_i = '0;
    logic [1:0]  trig_mode_i = '0;
    logic        busy_o, trig_o, done_o, rd_valid_o, rd_last_o;
    logic [15:0] rd_data_o;
    logic        rd_ready_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int smp      = 0;
    int pat_sel  = 0;
    logic [15:0] rd_buf [16];
    int got_n, last_cnt, last_idx, first_cyc, last_cyc;

    always #5 clk_i = ~clk_i;

    la_capture_core #(
        .DATA_W    (16),
        .TRIG_W    (8),
        .DEPTH     (16),
        .PRE_DEPTH (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .sample_en_i (sample_en_i),
        .data_i      (data_i),
        .trig_i      (trig_i),
        .trig_mask_i (trig_mask_i),
        .trig_val_i  (trig_val_i),
        .trig_mode_i (trig_mode_i),
        .busy_o      (busy_o),
        .trig_o      (trig_o),
        .done_o      (done_o),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .rd_last_o   (rd_last_o),
        .rd_ready_i  (rd_ready_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] trig_for(input int s);
        logic [7:0] t;
        t = '0;
        case (pat_sel)
            0: t = (s >= 20) ? 8'h01 : 8'h00;
            1: begin
                t    = ((s >= 10) && (s < 12)) ? 8'h00 : 8'h08;
                t[0] = s[0];
            end
            2: t = (s >= 25) ? 8'h04 : 8'h06;
            3: begin
                t[7:4] = (s < 7) ? 4'h3 : 4'h7;
                t[3:0] = s[3:0];
            end
            default: t = '0;
        endcase
        return t;
    endfunction

    task automatic arm(input logic [1:0] mode, input logic [7:0] mask, input logic [7:0] val);
        trig_mode_i = mode;
        trig_mask_i = mask;
        trig_val_i  = val;
        sample_en_i = 1'b0;
        arm_i       = 1'b1;
        @(posedge clk_i); #1;
        arm_i = 1'b0;
        smp   = 0;
    endtask

    // Feed counter samples until done_o or stop_smp qualified samples.
    task automatic run_until(input int stop_smp, input bit toggle);
        logic en;
        en = 1'b0;
        for (int c = 0; c < 300 && !done_o && smp < stop_smp; c++) begin
            en          = toggle ? ~en : 1'b1;
            sample_en_i = en;
            data_i      = en ? 16'(smp) : 16'hDEAD;
            trig_i      = trig_for(smp);
            @(posedge clk_i); #1;
            if (en) smp++;
        end
        sample_en_i = 1'b0;
        if (!done_o && smp < stop_smp) check_eq("capture_timeout", 32'(smp), 32'(stop_smp));
    endtask

    task automatic read_n(input int n, input bit rnd);
        bit          stall;
        logic [15:0] hold;
        got_n = 0; last_cnt = 0; last_idx = -1; first_cyc = 0; last_cyc = 0;
        stall = 0; hold = '0;
        for (int c = 0; c < 400 && got_n < n; c++) begin
            rd_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk_i);
            if (stall) check_eq("stall_hold", {15'd0, rd_valid_o, rd_data_o}, {15'd0, 1'b1, hold});
            if (rd_valid_o && rd_ready_i) begin
                rd_buf[got_n] = rd_data_o;
                if (rd_last_o) begin
                    last_cnt++;
                    last_idx = got_n;
                end
                if (got_n == 0) first_cyc = c;
                last_cyc = c;
                got_n++;
                stall = 0;
            end else if (rd_valid_o) begin
                stall = 1;
                hold  = rd_data_o;
            end else begin
                stall = 0;
            end
            @(posedge clk_i); #1;
        end
        rd_ready_i = 1'b0;
        if (got_n < n) check_eq("read_timeout", 32'(got_n), 32'(n));
    endtask

    task automatic check_readout(input string tag, input int first);
        check_eq({tag, "_count"}, 32'(got_n), 32'd16);
        check_eq({tag, "_last_cnt"}, 32'(last_cnt), 32'd1);
        check_eq({tag, "_last_idx"}, 32'(last_idx), 32'd15);
        check_eq({tag, "_trig_idx4"}, 32'(rd_buf[4]), 32'(first + 4));
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("%s_data%0d", tag, i), 32'(rd_buf[i]), 32'(first + i));
        check_eq({tag, "_done_clear"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_trig", 32'(trig_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_valid", 32'(rd_valid_o), 0);
        check_eq("rst_last", 32'(rd_last_o), 0);
        check_eq("rst_data", 32'(rd_data_o), 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // 1) LEVEL on bit0 at sample 20, full-rate readout.
        pat_sel = 0;
        arm(la_pkg::TM_LEVEL, 8'h01, 8'h01);
        check_eq("t1_busy", 32'(busy_o), 1);
        run_until(1000, 0);
        check_eq("t1_done", 32'(done_o), 1);
        check_eq("t1_trig", 32'(trig_o), 1);
        check_eq("t1_not_busy", 32'(busy_o), 0);
        read_n(16, 0);
        check_readout("t1", 16);
        check_eq("t1_throughput", 32'(last_cyc - first_cyc), 32'd15);

        // 2) RISE on bit3, already high at arm: fires only on the re-rise at sample 12.
        pat_sel = 1;
        arm(la_pkg::TM_RISE, 8'h08, 8'h00);
        run_until(12, 0);
        check_eq("t2_no_trig_yet", 32'(trig_o), 0);
        check_eq("t2_busy", 32'(busy_o), 1);
        run_until(1000, 0);
        check_eq("t2_trig", 32'(trig_o), 1);
        read_n(16, 0);
        check_readout("t2", 8);

        // 3) sample_en toggling; unqualified cycles carry 0xDEAD.
        pat_sel = 0;
        arm(la_pkg::TM_LEVEL, 8'h01, 8'h01);
        run_until(1000, 1);
        read_n(16, 0);
        check_readout("t3", 16);

        // 4) Random backpressure; LEVEL with a two-bit mask, trigger at 25.
        pat_sel = 2;
        arm(la_pkg::TM_LEVEL, 8'h06, 8'h04);
        run_until(1000, 0);
        read_n(16, 1);
        check_readout("t4", 21);

        // 5) Abort in POST (arm ignored there), then CHANGE capture.
        pat_sel = 0;
        arm(la_pkg::TM_LEVEL, 8'h01, 8'h01);
        run_until(25, 0);
        check_eq("t5_post_busy", 32'(busy_o), 1);
        check_eq("t5_post_trig", 32'(trig_o), 1);
        arm_i = 1'b1;
        @(posedge clk_i); #1;
        arm_i = 1'b0;
        check_eq("t5_arm_ignored_trig", 32'(trig_o), 1);
        check_eq("t5_arm_ignored_busy", 32'(busy_o), 1);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        check_eq("t5_abort_busy", 32'(busy_o), 0);
        check_eq("t5_abort_trig", 32'(trig_o), 0);
        check_eq("t5_abort_done", 32'(done_o), 0);
        check_eq("t5_abort_valid", 32'(rd_valid_o), 0);
        pat_sel = 3;
        arm(la_pkg::TM_CHANGE, 8'hF0, 8'h00);
        run_until(1000, 0);
        check_eq("t5_trig", 32'(trig_o), 1);
        read_n(16, 0);
        check_readout("t5", 3);

        // 6) Reset during READ after 7 handshakes, then a clean capture.
        pat_sel = 0;
        arm(la_pkg::TM_LEVEL, 8'h01, 8'h01);
        run_until(1000, 0);
        read_n(7, 0);
        check_eq("t6_partial_count", 32'(got_n), 32'd7);
        check_eq("t6_partial_data6", 32'(rd_buf[6]), 32'd22);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_eq("t6_rst_busy", 32'(busy_o), 0);
        check_eq("t6_rst_trig", 32'(trig_o), 0);
        check_eq("t6_rst_done", 32'(done_o), 0);
        check_eq("t6_rst_valid", 32'(rd_valid_o), 0);
        check_eq("t6_rst_last", 32'(rd_last_o), 0);
        check_eq("t6_rst_data", 32'(rd_data_o), 0);
        rst_i = 1'b0;
        rd_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("t6_no_partial_readout", 32'(rd_valid_o), 0);
        rd_ready_i = 1'b0;
        arm(la_pkg::TM_LEVEL, 8'h01, 8'h01);
        run_until(1000, 0);
        read_n(16, 0);
        check_readout("t6", 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
